fsm_dispatcher: RTL and testbench

Initiator for the `fsm` start/flag_done handshake. Accepts jobs on a valid/ready port, issues a one-cycle `start` pulse to the downstream FSM, waits for `flag_done`, and reports each job's completion with its ID. A watchdog bounds the wait; completions are counted and errors are latched as sticky flags.

---
 rtl/fsm_dispatcher.sv | 202 ++++++++++++++++++++
 tb/tb_fsm_dispatcher.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_dispatcher.sv
// -----------------------------------------------------------------------------
// fsm_dispatcher
//
// Initiator for the downstream FSM start/flag_done handshake. A job offered on
// the valid/ready port is turned into a single-cycle start pulse. The block
// then waits for flag_done under a watchdog and reports each completion with
// the job ID and an error qualifier. Successful completions are counted, and
// timeouts and out-of-window flag_done strobes are latched as sticky errors.
//
// Optional feature (compile-time macro DISPATCH_QUEUE_EN):
//   Adds a one-entry pending-job slot. This lets the next job be accepted
//   while one is in flight and issued straight out of COOL.
//
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles allowed without flag_done (>= 2)
//   ID_W           : job ID width
//   CNT_W          : completion counter width
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   job_valid    in   job request
//   job_id       in   ID of the offered job
//   job_ready    out  dispatcher can accept a job
//   start        out  one-cycle start pulse to the FSM (registered)
//   flag_done    in   completion strobe from the FSM
//   busy         out  a job is in flight (state other than IDLE)
//   done_valid   out  one-cycle completion strobe (registered)
//   done_id      out  ID of the completed job, held until the next done_valid
//   done_err     out  qualifies done_valid: 1 means the job timed out
//   timeout_err  out  sticky, set on any timeout
//   spurious_err out  sticky, set when flag_done arrives outside WAIT
//   err_clr      in   synchronous clear of both sticky flags (set wins)
//   job_count    out  count of successful completions, wraps
// -----------------------------------------------------------------------------
module fsm_dispatcher #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ID_W           = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  input  logic [ID_W-1:0]  job_id,
  output logic             job_ready,
  output logic             start,
  input  logic             flag_done,
  output logic             busy,
  output logic             done_valid,
  output logic [ID_W-1:0]  done_id,
  output logic             done_err,
  output logic             timeout_err,
  output logic             spurious_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] job_count
);

  localparam int WCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    COOL  = 2'd3
  } state_t;

  state_t            state_r;
  logic [WCNT_W-1:0] wait_cnt_r;
  // The first WAIT cycle is the FSM's start-capture cycle, so it is not
  // charged against the watchdog budget.
  logic              wait_grace_r;
  logic [ID_W-1:0]   inflight_id_r;
  logic              accept_s;

`ifdef DISPATCH_QUEUE_EN
  logic              pend_valid_r;
  logic [ID_W-1:0]   pend_id_r;

  // The slot may be refilled in the same COOL cycle that drains it.
  assign job_ready = !pend_valid_r || (state_r == COOL);
`else
  assign job_ready = (state_r == IDLE);
`endif

  assign accept_s = job_valid && job_ready;
  assign busy     = (state_r != IDLE);

  // Dispatcher FSM, watchdog, completion reporting and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      wait_cnt_r    <= '0;
      wait_grace_r  <= 1'b0;
      inflight_id_r <= '0;
      start         <= 1'b0;
      done_valid    <= 1'b0;
      done_id       <= '0;
      done_err      <= 1'b0;
      timeout_err   <= 1'b0;
      spurious_err  <= 1'b0;
      job_count     <= '0;
`ifdef DISPATCH_QUEUE_EN
      pend_valid_r  <= 1'b0;
      pend_id_r     <= '0;
`endif
    end else begin
      // Strobes default low; they are raised for exactly one cycle below.
      start      <= 1'b0;
      done_valid <= 1'b0;

      // Clear first so that any set further down in this block wins.
      if (err_clr) begin
        timeout_err  <= 1'b0;
        spurious_err <= 1'b0;
      end

      if (flag_done && (state_r != WAIT)) begin
        spurious_err <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (accept_s) begin
            inflight_id_r <= job_id;
            start         <= 1'b1;
            state_r       <= ISSUE;
          end
        end

        ISSUE: begin
          wait_cnt_r   <= '0;
          wait_grace_r <= 1'b1;
          state_r      <= WAIT;
`ifdef DISPATCH_QUEUE_EN
          if (accept_s) begin
            pend_valid_r <= 1'b1;
            pend_id_r    <= job_id;
          end
`endif
        end

        WAIT: begin
`ifdef DISPATCH_QUEUE_EN
          if (accept_s) begin
            pend_valid_r <= 1'b1;
            pend_id_r    <= job_id;
          end
`endif
          // flag_done is tested first so it wins a tie with the timeout.
          if (flag_done) begin
            done_valid <= 1'b1;
            done_err   <= 1'b0;
            done_id    <= inflight_id_r;
            job_count  <= job_count + CNT_W'(1);
            state_r    <= COOL;
          end else if (wait_grace_r) begin
            wait_grace_r <= 1'b0;
          end else if (wait_cnt_r == WAIT_LAST) begin
            done_valid  <= 1'b1;
            done_err    <= 1'b1;
            done_id     <= inflight_id_r;
            timeout_err <= 1'b1;
            state_r     <= COOL;
          end else begin
            wait_cnt_r <= wait_cnt_r + WCNT_W'(1);
          end
        end

        COOL: begin
          // COOL covers the FSM's DONE state so that start never lands
          // while the FSM is outside IDLE.
`ifdef DISPATCH_QUEUE_EN
          if (pend_valid_r) begin
            inflight_id_r <= pend_id_r;
            start         <= 1'b1;
            state_r       <= ISSUE;
            if (accept_s) begin
              pend_id_r <= job_id;
            end else begin
              pend_valid_r <= 1'b0;
            end
          end else if (accept_s) begin
            inflight_id_r <= job_id;
            start         <= 1'b1;
            state_r       <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
`else
          state_r <= IDLE;
`endif
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_dispatcher.sv
module tb_fsm_dispatcher;

  localparam int ID_W  = 4;
  localparam int CNT_W = 8;
`ifdef DISPATCH_QUEUE_EN
  localparam int SPACING = 4;
`else
  localparam int SPACING = 5;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             job_valid = 1'b0;
  logic [ID_W-1:0]  job_id = '0;
  logic             job_ready;
  logic             start;
  logic             flag_done;
  logic             busy;
  logic             done_valid;
  logic [ID_W-1:0]  done_id;
  logic             done_err;
  logic             timeout_err;
  logic             spurious_err;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] job_count;

  int checks   = 0;
  int failures = 0;

  // Model FSM: raises flag_done two cycles after it sees start (its EXEC).
  logic       model_en    = 1'b0;
  logic       manual_done = 1'b0;
  logic [1:0] sh;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) sh <= 2'b00;
    else     sh <= {sh[0], start};
  end

  assign flag_done = manual_done | (model_en & sh[1]);

  fsm_dispatcher #(.TIMEOUT_CYCLES(16), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_id(job_id),
    .job_ready(job_ready), .start(start), .flag_done(flag_done), .busy(busy),
    .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
    .timeout_err(timeout_err), .spurious_err(spurious_err), .err_clr(err_clr),
    .job_count(job_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (start !== 1'b0)       begin failures++; $display("FAIL reset_start: got %b want 0", start); end
    checks++; if (done_valid !== 1'b0)  begin failures++; $display("FAIL reset_done_valid: got %b want 0", done_valid); end
    checks++; if (job_ready !== 1'b1)   begin failures++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (job_count !== 8'd0)   begin failures++; $display("FAIL reset_job_count: got %0d want 0", job_count); end
    checks++; if ({timeout_err, spurious_err, done_err} !== 3'b000) begin failures++; $display("FAIL reset_errs: got %b want 000", {timeout_err, spurious_err, done_err}); end
    checks++; if (done_id !== 4'h0)     begin failures++; $display("FAIL reset_done_id: got %h want 0", done_id); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    model_en  = 1'b1;
    job_valid = 1'b1;
    job_id    = 4'h5;
    tick(); // c+1
    job_valid = 1'b0;
    checks++; if (start !== 1'b1)     begin failures++; $display("FAIL single_start_c1: got %b want 1", start); end
    checks++; if (job_ready !== 1'b0) begin failures++; $display("FAIL single_ready_c1: got %b want 0", job_ready); end
    checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL single_busy_c1: got %b want 1", busy); end
    tick(); // c+2
    checks++; if (start !== 1'b0)     begin failures++; $display("FAIL single_start_c2: got %b want 0", start); end
    tick(); // c+3
    checks++; if ({start, done_valid} !== 2'b00) begin failures++; $display("FAIL single_c3: got %b want 00", {start, done_valid}); end
    tick(); // c+4
    checks++; if (done_valid !== 1'b1) begin failures++; $display("FAIL single_done_valid: got %b want 1", done_valid); end
    checks++; if (done_id !== 4'h5)    begin failures++; $display("FAIL single_done_id: got %h want 5", done_id); end
    checks++; if (done_err !== 1'b0)   begin failures++; $display("FAIL single_done_err: got %b want 0", done_err); end
    checks++; if (job_count !== 8'd1)  begin failures++; $display("FAIL single_job_count: got %0d want 1", job_count); end
    checks++; if (job_ready !== 1'b0)  begin failures++; $display("FAIL single_ready_c4: got %b want 0", job_ready); end
    tick(); // c+5
    checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL single_done_valid_c5: got %b want 0", done_valid); end
    checks++; if (job_ready !== 1'b1)  begin failures++; $display("FAIL single_ready_c5: got %b want 1", job_ready); end
    checks++; if (done_id !== 4'h5)    begin failures++; $display("FAIL single_done_id_hold: got %h want 5", done_id); end
  endtask

  task automatic test_timeout;
    int k;
    model_en  = 1'b0;
    job_valid = 1'b1;
    job_id    = 4'h9;
    tick(); // start cycle
    job_valid = 1'b0;
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL timeout_start: got %b want 1", start); end
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_valid === 1'b1) begin
        k = i;
        break;
      end
    end
    checks++; if (k != 18)             begin failures++; $display("FAIL timeout_latency: got %0d want 18", k); end
    checks++; if (done_err !== 1'b1)   begin failures++; $display("FAIL timeout_done_err: got %b want 1", done_err); end
    checks++; if (done_id !== 4'h9)    begin failures++; $display("FAIL timeout_done_id: got %h want 9", done_id); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
    checks++; if (job_count !== 8'd1)  begin failures++; $display("FAIL timeout_job_count: got %0d want 1", job_count); end
    tick(); tick(); tick();
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky_hold: got %b want 1", timeout_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_race;
    model_en  = 1'b0;
    job_valid = 1'b1;
    job_id    = 4'h3;
    tick(); // start cycle s
    job_valid = 1'b0;
    for (int i = 0; i < 17; i++) tick(); // s+17: last WAIT cycle
    checks++; if (done_valid !== 1'b0) begin failures++; $display("FAIL race_early_done: got %b want 0", done_valid); end
    manual_done = 1'b1;
    tick(); // s+18
    manual_done = 1'b0;
    checks++; if (done_valid !== 1'b1)  begin failures++; $display("FAIL race_done_valid: got %b want 1", done_valid); end
    checks++; if (done_err !== 1'b0)    begin failures++; $display("FAIL race_done_err: got %b want 0", done_err); end
    checks++; if (done_id !== 4'h3)     begin failures++; $display("FAIL race_done_id: got %h want 3", done_id); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL race_timeout_err: got %b want 0", timeout_err); end
    checks++; if (spurious_err !== 1'b0) begin failures++; $display("FAIL race_spurious_err: got %b want 0", spurious_err); end
    checks++; if (job_count !== 8'd2)   begin failures++; $display("FAIL race_job_count: got %0d want 2", job_count); end
    tick(); tick();
  endtask

  task automatic test_spurious;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_idle: got busy=%b want 0", busy); end
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    checks++; if (spurious_err !== 1'b1) begin failures++; $display("FAIL spur_set: got %b want 1", spurious_err); end
    checks++; if (job_count !== 8'd2)    begin failures++; $display("FAIL spur_job_count: got %0d want 2", job_count); end
    checks++; if ({busy, done_valid} !== 2'b00) begin failures++; $display("FAIL spur_state: got %b want 00", {busy, done_valid}); end
    err_clr     = 1'b1;
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    checks++; if (spurious_err !== 1'b1) begin failures++; $display("FAIL spur_set_wins: got %b want 1", spurious_err); end
    tick();
    err_clr = 1'b0;
    checks++; if (spurious_err !== 1'b0) begin failures++; $display("FAIL spur_clear: got %b want 0", spurious_err); end
  endtask

  task automatic test_back_to_back;
    int n_acc, n_done, last_start;
    logic [3:0] exp_id;
    n_acc      = 0;
    n_done     = 0;
    last_start = -1;
    model_en   = 1'b1;
    for (int cyc = 0; cyc < 4000 && n_done < 300; cyc++) begin
      if (start === 1'b1) begin
        if (last_start >= 0) begin
          checks++;
          if (cyc - last_start != SPACING) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_start, SPACING);
          end
        end
        last_start = cyc;
      end
      if (done_valid === 1'b1) begin
        exp_id = n_done[3:0];
        checks++;
        if ({done_err, done_id} !== {1'b0, exp_id}) begin
          failures++;
          $display("FAIL b2b_done: got err=%b id=%h want err=0 id=%h", done_err, done_id, exp_id);
        end
        n_done++;
      end
      job_valid = (n_acc < 300);
      job_id    = n_acc[3:0];
      if (job_valid && job_ready === 1'b1) n_acc++;
      tick();
    end
    job_valid = 1'b0;
    checks++; if (n_done != 300)       begin failures++; $display("FAIL b2b_completions: got %0d want 300", n_done); end
    checks++; if (job_count !== 8'd44) begin failures++; $display("FAIL b2b_job_count: got %0d want 44", job_count); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_job;
    int dv_seen;
    model_en  = 1'b0;
    job_valid = 1'b1;
    job_id    = 4'hA;
    tick(); // ISSUE
    job_valid = 1'b0;
    tick(); tick(); // WAIT
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, start, done_valid, job_ready} !== 4'b0001) begin failures++; $display("FAIL midrst_ctrl: got %b want 0001", {busy, start, done_valid, job_ready}); end
    checks++; if (job_count !== 8'd0) begin failures++; $display("FAIL midrst_job_count: got %0d want 0", job_count); end
    checks++; if ({timeout_err, spurious_err, done_err, done_id} !== 7'd0) begin failures++; $display("FAIL midrst_status: got %h want 0", {timeout_err, spurious_err, done_err, done_id}); end
    tick();
    rst = 1'b0;
    model_en = 1'b1;
    dv_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_valid === 1'b1 || start === 1'b1) dv_seen++;
    end
    checks++; if (dv_seen != 0) begin failures++; $display("FAIL midrst_no_done: got %0d strobes want 0", dv_seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_race();
    test_spurious();
    test_reset();
    test_back_to_back();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
